classifier_ctrl: RTL
====================

# classifier_ctrl

Sequencer that drives the `classifier` from the planar 4-channel feature buffer (196 words: channels 0–3, 49 words each, channel-major).

- On `start` it does four things:
  - clears the classifier accumulators;
  - gathers the four channel words of each of the 49 positions from a single-port, one-cycle-latency RAM;
  - issues each gathered position as one `cls_valid` beat;
  - waits for `cls_done`, then latches the class.
- A timeout watchdog flags a classifier that never completes.
- It sits between the pooling-stage feature buffer and the classifier.

## Interface
- `CH`, 4, channels per position
- `CH_SIZE`, 49, positions per channel
- `DW`, 16, data width (signed)
- `AW`, 8, buffer address width
- `TIMEOUT`, 1000, max WAIT cycles before error

Ports:
- `clk` in 1: single clock, rising edge
- `reset_n` in 1: asynchronous, active-low reset; all state and outputs return to reset values immediately
- `start` in 1: one-cycle request to classify the buffered frame
- `busy` out 1: high from the cycle after `start` is accepted until return to IDLE; reset 0
- `mem_rd_en` out 1: buffer read strobe; reset 0
- `mem_addr` out AW: buffer read address; reset 0
- `mem_rdata` in DW: read data, valid the cycle after `mem_rd_en`
- `cls_clear` out 1: one-cycle synchronous clear to the classifier; reset 0
- `cls_pixel` out CH×DW: registered position data, lane k = channel k; reset all 0
- `cls_valid` out 1: one-cycle beat per position; reset 0
- `cls_done` in 1: classifier completion
- `cls_result` in 4: classifier class index
- `result` out 4: latched class; reset 0, holds until the next completion
- `result_valid` out 1: one-cycle pulse on completion; reset 0
- `error` out 1: sticky timeout flag, cleared when the next `start` is accepted; reset 0

## Operation
- States: IDLE, CLEAR, FETCH, ISSUE, WAIT.
- IDLE:
  - `start` moves to CLEAR and clears `error`.
  - `start` in any other state is ignored.
- CLEAR: `cls_clear`=1 for one cycle; position counter p=0, channel counter k=0; go to FETCH.
- FETCH:
  - Four cycles, k=0..3, with `mem_rd_en`=1 and `mem_addr`=p+k·CH_SIZE.
  - Read data is captured into lane k at the end of the following cycle.
  - After k=3, go to ISSUE.
- ISSUE:
  - One cycle. Lane 3 is taken directly from `mem_rdata`.
  - At the end of ISSUE, `cls_pixel` loads lanes 0–2 plus `mem_rdata`, and `cls_valid` is registered high for the next cycle only.
  - If p<CH_SIZE−1: p++, go to FETCH.
  - Otherwise go to WAIT, with the watchdog counter at 0.
- `cls_pixel` holds its value until the next ISSUE load.
- The classifier accepts gapped `cls_valid` beats; beats are 5 cycles apart.
- WAIT:
  - The watchdog counter increments each cycle.
  - On `cls_done`: `result`←`cls_result`, `result_valid` pulses, go to IDLE.
  - If the counter reaches TIMEOUT without `cls_done`: `error`=1, no `result_valid`, go to IDLE.
  - If `cls_done` arrives in the same cycle the counter reaches TIMEOUT, `cls_done` wins.
- `cls_done` outside WAIT is ignored.
- Address arithmetic is unsigned AW-bit; the maximum address is 195, so it never wraps.

## Timing
- `start` is sampled at cycle 0; CLEAR is cycle 1; first FETCH is cycle 2.
- Position p: `cls_valid` high in cycle 7+5p. The last beat (p=48) is cycle 247.
- WAIT begins in cycle 247.
- `result_valid` is asserted the cycle after `cls_done` is sampled.
- `busy` drops in that same cycle.
- `reset_n` low mid-frame aborts the frame: no `result_valid`, `result` returns to 0, `cls_clear` is not issued. The next `start` restarts from p=0.

## Structure
- Shared package `classifier_pkg`:
  - `CH`, `CH_SIZE`, `DW` constants;
  - the state enum `cls_ctrl_state_t`;
  - a `pixel_vec_t` typedef (CH×signed DW) used by both this block and `classifier`.
- Single module; no sub-module. Lane gather and watchdog stay inline.

## Test plan
- Ramp buffer, `mem[i]`=i; `start`:
  - beat p carries {p, p+49, p+98, p+147};
  - exactly 49 beats;
  - first beat at cycle 7, spacing 5;
  - `cls_clear` seen once at cycle 1.
- Model classifier asserts `cls_done` with `cls_result`=7, 3 cycles after the last beat → `result`=7, `result_valid` one cycle, `busy` low; `error`=0.
- `cls_done` never asserted → `error`=1 after 1000 WAIT cycles, no `result_valid`. The next `start` clears `error`.
- `start` pulsed during FETCH and during WAIT → ignored; beat count stays 49.
- `reset_n` low at cycle 100 → all outputs 0 asynchronously. A new `start` yields a correct full frame.
- Two back-to-back frames with different buffer contents and `cls_result` 3 then 9 → `result` 3 then 9, with `cls_clear` before each frame.

Source files
------------

// File: rtl/classifier_pkg.sv
// Shared types and constants for the classifier and its sequencer.
// Holds the planar feature-buffer geometry, position vector type and controller states.
package classifier_pkg;

    localparam int CH      = 4;
    localparam int CH_SIZE = 49;
    localparam int DW      = 16;

    typedef logic signed [DW-1:0] word_t;
    typedef word_t [CH-1:0] pixel_vec_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FETCH = 3'd2,
        S_ISSUE = 3'd3,
        S_WAIT  = 3'd4
    } cls_ctrl_state_t;

endpackage

// File: rtl/classifier_ctrl_if.sv
// Bundle of the request, feature-buffer and classifier signals around classifier_ctrl.
// The master side is the sequencer; the slave side is its environment.
interface classifier_ctrl_if
    import classifier_pkg::*;
#(
    parameter int AW = 8
) ();

    logic          start;
    logic          busy;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    word_t         mem_rdata;
    logic          cls_clear;
    pixel_vec_t    cls_pixel;
    logic          cls_valid;
    logic          cls_done;
    logic [3:0]    cls_result;
    logic [3:0]    result;
    logic          result_valid;
    logic          error;

    modport master (
        input  start, mem_rdata, cls_done, cls_result,
        output busy, mem_rd_en, mem_addr, cls_clear, cls_pixel, cls_valid,
               result, result_valid, error
    );

    modport slave (
        output start, mem_rdata, cls_done, cls_result,
        input  busy, mem_rd_en, mem_addr, cls_clear, cls_pixel, cls_valid,
               result, result_valid, error
    );

endinterface

// File: rtl/classifier_ctrl.sv
// Sequencer that gathers each position's four channel words from the planar buffer,
// feeds them to the classifier one beat at a time and latches the resulting class.
module classifier_ctrl
    import classifier_pkg::*;
#(
    parameter int AW      = 8,
    parameter int TIMEOUT = 1000
) (
    input  logic               clk,
    input  logic               reset_n,
    classifier_ctrl_if.master  bus
);

    localparam int PW  = $clog2(CH_SIZE);
    localparam int KW  = $clog2(CH);
    localparam int WDW = $clog2(TIMEOUT + 1);

    localparam logic [AW-1:0]  ADDR_STRIDE = AW'(CH_SIZE);
    localparam logic [PW-1:0]  P_LAST      = PW'(CH_SIZE - 1);
    localparam logic [KW-1:0]  K_LAST      = KW'(CH - 1);
    localparam logic [WDW-1:0] WD_LAST     = WDW'(TIMEOUT - 1);

    cls_ctrl_state_t r_state;
    logic [PW-1:0]   r_p;
    logic [KW-1:0]   r_k;
    logic [WDW-1:0]  r_wd;
    word_t           r_lane [0:CH-2];
    logic            r_busy;
    logic            r_mem_rd_en;
    logic [AW-1:0]   r_mem_addr;
    logic            r_cls_clear;
    pixel_vec_t      r_cls_pixel;
    logic            r_cls_valid;
    logic [3:0]      r_result;
    logic            r_result_valid;
    logic            r_error;

    // Frame sequencer: state, counters, lane gather, watchdog and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_p            <= '0;
            r_k            <= '0;
            r_wd           <= '0;
            for (int i = 0; i < CH - 1; i++) r_lane[i] <= '0;
            r_busy         <= 1'b0;
            r_mem_rd_en    <= 1'b0;
            r_mem_addr     <= '0;
            r_cls_clear    <= 1'b0;
            r_cls_pixel    <= '0;
            r_cls_valid    <= 1'b0;
            r_result       <= 4'd0;
            r_result_valid <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_cls_clear    <= 1'b0;
            r_cls_valid    <= 1'b0;
            r_result_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state     <= S_CLEAR;
                        r_cls_clear <= 1'b1;
                        r_busy      <= 1'b1;
                        r_error     <= 1'b0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CLEAR: begin
                    r_p         <= '0;
                    r_k         <= '0;
                    r_mem_rd_en <= 1'b1;
                    r_mem_addr  <= '0;
                    r_state     <= S_FETCH;
                end
                S_FETCH: begin
                    // Read k-1 returns during read k; the final channel is taken live in ISSUE.
                    if (r_k != '0) begin
                        r_lane[r_k - KW'(1)] <= bus.mem_rdata;
                    end
                    if (r_k == K_LAST) begin
                        r_k         <= '0;
                        r_mem_rd_en <= 1'b0;
                        r_state     <= S_ISSUE;
                    end else begin
                        r_k        <= r_k + KW'(1);
                        r_mem_addr <= r_mem_addr + ADDR_STRIDE;
                    end
                end
                S_ISSUE: begin
                    for (int i = 0; i < CH - 1; i++) r_cls_pixel[i] <= r_lane[i];
                    r_cls_pixel[CH-1] <= bus.mem_rdata;
                    r_cls_valid       <= 1'b1;
                    if (r_p < P_LAST) begin
                        r_p         <= r_p + PW'(1);
                        r_mem_addr  <= AW'(r_p + PW'(1));
                        r_mem_rd_en <= 1'b1;
                        r_state     <= S_FETCH;
                    end else begin
                        r_wd    <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A completion in the watchdog's final cycle still counts as success.
                    if (bus.cls_done) begin
                        r_result       <= bus.cls_result;
                        r_result_valid <= 1'b1;
                        r_busy         <= 1'b0;
                        r_state        <= S_IDLE;
                    end else if (r_wd == WD_LAST) begin
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_wd <= r_wd + WDW'(1);
                    end
                end
                default: begin
                    r_busy      <= 1'b0;
                    r_mem_rd_en <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy         = r_busy;
    assign bus.mem_rd_en    = r_mem_rd_en;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.cls_clear    = r_cls_clear;
    assign bus.cls_pixel    = r_cls_pixel;
    assign bus.cls_valid    = r_cls_valid;
    assign bus.result       = r_result;
    assign bus.result_valid = r_result_valid;
    assign bus.error        = r_error;

endmodule
